// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60Hz raster constants; renderers import this for the visible dimensions.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  typedef logic [9:0] coord_t;

  function automatic coord_t to_coord(input int value);
    return coord_t'(value);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it (master), renderers and the connector read it (slave).
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic       hs;
  logic       vs;
  logic       blank;
  logic       sync;
  coord_t     DrawX;
  coord_t     DrawY;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output hs, vs, blank, sync, DrawX, DrawY, frame_start, frame_count
  );

  modport slave (
    input hs, vs, blank, sync, DrawX, DrawY, frame_start, frame_count
  );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus sync, blank and frame strobes,
// all registered and aligned with the DrawX/DrawY values they describe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam coord_t H_LAST   = to_coord(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST   = to_coord(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_ACTIVE = to_coord(H_VISIBLE);
  localparam coord_t V_ACTIVE = to_coord(V_VISIBLE);
  localparam coord_t HS_LO    = to_coord(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI    = to_coord(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_LO    = to_coord(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI    = to_coord(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       running;
  coord_t     h_cnt;
  coord_t     v_cnt;
  coord_t     h_next;
  coord_t     v_next;
  logic       line_end;
  logic       frame_end;
  logic       hs_q;
  logic       vs_q;
  logic       blank_q;
  logic       frame_start_q;
  logic [7:0] frame_count_q;

  // The first edge out of reset holds (0,0) so that origin is presented with its flags.
  always_comb begin
    line_end  = (h_cnt == H_LAST);
    frame_end = line_end && (v_cnt == V_LAST);
    h_next    = '0;
    v_next    = '0;
    if (running) begin
      h_next = line_end ? '0 : h_cnt + 10'd1;
      v_next = v_cnt;
      if (line_end) begin
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end
    end
  end

  // Flags are decoded from the next counter values so they land on the same cycle as DrawX/DrawY.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      running       <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      running       <= 1'b1;
      h_cnt         <= h_next;
      v_cnt         <= v_next;
      blank_q       <= (h_next < H_ACTIVE) && (v_next < V_ACTIVE);
      hs_q          <= !((h_next >= HS_LO) && (h_next <= HS_HI));
      vs_q          <= !((v_next >= VS_LO) && (v_next <= VS_HI));
      frame_start_q <= (h_next == '0) && (v_next == '0);
      if (running && frame_end) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank       = blank_q;
  assign vga.sync        = 1'b0;
  assign vga.DrawX       = h_cnt;
  assign vga.DrawY       = v_cnt;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a shrunken
// instance (16x10 raster) for frame-level timing and frame_count wrap.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int SMALL_H_TOTAL = 16;
  localparam int SMALL_V_TOTAL = 10;
  localparam int SMALL_FRAME   = SMALL_H_TOTAL * SMALL_V_TOTAL;
  localparam int RUN_FRAMES    = 257;
  localparam int NUM_VECTORS   = 23;

  typedef struct {
    int rst;
    int cycles;
    int x;
    int y;
    int hs;
    int vs;
    int blank;
    int fs;
    int fc;
  } vector_t;

  logic vgaClk = 1'b0;
  logic reset;

  int assertCount = 0;
  int failCount   = 0;

  vga_timing_gen_if fullIf ();
  vga_timing_gen_if smallIf ();

  vga_timing_gen dutFull (
    .vga_clk (vgaClk),
    .reset   (reset),
    .vga     (fullIf)
  );

  // Small raster: H 8/2/3/3 (hs low at X 10..12), V 4/1/2/3 (vs low at Y 5..6).
  vga_timing_gen #(
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_VISIBLE (4),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (3)
  ) dutSmall (
    .vga_clk (vgaClk),
    .reset   (reset),
    .vga     (smallIf)
  );

  always #20 vgaClk = ~vgaClk;

  task automatic applyStimulus(input int rst, input int cycles);
    reset = (rst != 0);
    repeat (cycles) @(negedge vgaClk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  vector_t vectors [NUM_VECTORS];

  int         lastFs;
  int         fsCount;
  int         badPeriods;
  int         fcOffPulse;
  int         wrapSeen;
  logic [7:0] prevFc;
  int         vsLow;
  int         vsStartX;
  int         vsStartY;
  int         smallBlank;
  int         lastZero;
  int         lineLen;
  int         hsLow;
  int         hsStartX;
  int         fullBlank;

  initial begin
    reset = 1'b1;

    //              rst cyc   X  Y hs vs bl fs fc
    vectors[0]  = '{1,   5,   0, 0, 1, 1, 0, 0, 0};
    vectors[1]  = '{0,   1,   0, 0, 1, 1, 1, 1, 0};
    vectors[2]  = '{0,   1,   1, 0, 1, 1, 1, 0, 0};
    vectors[3]  = '{0,   6,   7, 0, 1, 1, 1, 0, 0};
    vectors[4]  = '{0,   1,   8, 0, 1, 1, 0, 0, 0};
    vectors[5]  = '{0,   1,   9, 0, 1, 1, 0, 0, 0};
    vectors[6]  = '{0,   1,  10, 0, 0, 1, 0, 0, 0};
    vectors[7]  = '{0,   2,  12, 0, 0, 1, 0, 0, 0};
    vectors[8]  = '{0,   1,  13, 0, 1, 1, 0, 0, 0};
    vectors[9]  = '{0,   2,  15, 0, 1, 1, 0, 0, 0};
    vectors[10] = '{0,   1,   0, 1, 1, 1, 1, 0, 0};
    vectors[11] = '{0,  39,   7, 3, 1, 1, 1, 0, 0};
    vectors[12] = '{0,   9,   0, 4, 1, 1, 0, 0, 0};
    vectors[13] = '{0,  16,   0, 5, 1, 0, 0, 0, 0};
    vectors[14] = '{0,  26,  10, 6, 0, 0, 0, 0, 0};
    vectors[15] = '{0,   6,   0, 7, 1, 1, 0, 0, 0};
    vectors[16] = '{0,  47,  15, 9, 1, 1, 0, 0, 0};
    vectors[17] = '{0,   1,   0, 0, 1, 1, 1, 1, 1};
    vectors[18] = '{0,   1,   1, 0, 1, 1, 1, 0, 1};
    vectors[19] = '{0,  36,   5, 2, 1, 1, 1, 0, 1};
    vectors[20] = '{1,   1,   0, 0, 1, 1, 0, 0, 0};
    vectors[21] = '{0,   1,   0, 0, 1, 1, 1, 1, 0};
    vectors[22] = '{0,   1,   1, 0, 1, 1, 1, 0, 0};

    for (int i = 0; i < NUM_VECTORS; i++) begin
      applyStimulus(vectors[i].rst, vectors[i].cycles);
      checkOutput($sformatf("vec%0d DrawX", i), int'(smallIf.DrawX), vectors[i].x);
      checkOutput($sformatf("vec%0d DrawY", i), int'(smallIf.DrawY), vectors[i].y);
      checkOutput($sformatf("vec%0d hs", i), int'(smallIf.hs), vectors[i].hs);
      checkOutput($sformatf("vec%0d vs", i), int'(smallIf.vs), vectors[i].vs);
      checkOutput($sformatf("vec%0d blank", i), int'(smallIf.blank), vectors[i].blank);
      checkOutput($sformatf("vec%0d frame_start", i), int'(smallIf.frame_start), vectors[i].fs);
      checkOutput($sformatf("vec%0d frame_count", i), int'(smallIf.frame_count), vectors[i].fc);
    end
    checkOutput("small sync", int'(smallIf.sync), 0);

    // Full-size instance: reset values, then the first cycle after release.
    applyStimulus(1, 3);
    checkOutput("full reset DrawX", int'(fullIf.DrawX), 0);
    checkOutput("full reset DrawY", int'(fullIf.DrawY), 0);
    checkOutput("full reset hs", int'(fullIf.hs), 1);
    checkOutput("full reset vs", int'(fullIf.vs), 1);
    checkOutput("full reset blank", int'(fullIf.blank), 0);
    checkOutput("full reset frame_start", int'(fullIf.frame_start), 0);
    checkOutput("full reset frame_count", int'(fullIf.frame_count), 0);
    applyStimulus(0, 1);
    checkOutput("full start DrawX", int'(fullIf.DrawX), 0);
    checkOutput("full start DrawY", int'(fullIf.DrawY), 0);
    checkOutput("full start blank", int'(fullIf.blank), 1);
    checkOutput("full start frame_start", int'(fullIf.frame_start), 1);
    checkOutput("full start hs", int'(fullIf.hs), 1);
    checkOutput("full sync", int'(fullIf.sync), 0);

    lastFs     = -1;
    fsCount    = 0;
    badPeriods = 0;
    fcOffPulse = 0;
    wrapSeen   = 0;
    prevFc     = 8'd0;
    vsLow      = 0;
    vsStartX   = -1;
    vsStartY   = -1;
    smallBlank = 0;
    lastZero   = -1;
    lineLen    = -1;
    hsLow      = 0;
    hsStartX   = -1;
    fullBlank  = 0;

    // Cycle c = 0 is the (0,0) cycle just sampled; watch both instances cycle by cycle.
    for (int c = 0; c <= RUN_FRAMES * SMALL_FRAME; c++) begin
      if (c > 0) @(negedge vgaClk);

      if (smallIf.frame_start) begin
        if (lastFs >= 0 && (c - lastFs) != SMALL_FRAME) badPeriods++;
        lastFs = c;
        fsCount++;
      end
      if (smallIf.frame_count != prevFc) begin
        if (!smallIf.frame_start) fcOffPulse++;
        if (prevFc == 8'd255 && smallIf.frame_count == 8'd0) wrapSeen = 1;
      end
      prevFc = smallIf.frame_count;
      if (c < SMALL_FRAME) begin
        if (!smallIf.vs) begin
          if (vsLow == 0) begin
            vsStartX = int'(smallIf.DrawX);
            vsStartY = int'(smallIf.DrawY);
          end
          vsLow++;
        end
        if (smallIf.blank) smallBlank++;
      end

      if (c < 1600) begin
        if (fullIf.DrawX == 10'd0) begin
          if (lastZero >= 0 && lineLen < 0) lineLen = c - lastZero;
          lastZero = c;
        end
        if (c < 800) begin
          if (!fullIf.hs) begin
            if (hsLow == 0) hsStartX = int'(fullIf.DrawX);
            hsLow++;
          end
          if (fullIf.blank) fullBlank++;
        end
        if (c == 639) checkOutput("full blank at (639,0)", int'(fullIf.blank), 1);
        if (c == 640) checkOutput("full blank at (640,0)", int'(fullIf.blank), 0);
        if (c == 800) begin
          checkOutput("full DrawX after line", int'(fullIf.DrawX), 0);
          checkOutput("full DrawY after line", int'(fullIf.DrawY), 1);
        end
      end
    end

    checkOutput("full line length", lineLen, 800);
    checkOutput("full hs low cycles", hsLow, 96);
    checkOutput("full hs first low DrawX", hsStartX, 656);
    checkOutput("full blank=1 cycles per line", fullBlank, 640);
    checkOutput("small frame_start count", fsCount, RUN_FRAMES + 1);
    checkOutput("small bad frame periods", badPeriods, 0);
    checkOutput("small frame_count change off pulse", fcOffPulse, 0);
    checkOutput("small frame_count 255->0 seen", wrapSeen, 1);
    checkOutput("small final frame_count", int'(smallIf.frame_count), 1);
    checkOutput("small final frame_start", int'(smallIf.frame_start), 1);
    checkOutput("small vs low cycles", vsLow, 2 * SMALL_H_TOTAL);
    checkOutput("small vs start DrawX", vsStartX, 0);
    checkOutput("small vs start DrawY", vsStartY, 5);
    checkOutput("small blank=1 cycles per frame", smallBlank, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
